rename_queue: RTL and testbench

//  Decoupling FIFO between decode and rename. Holds up to DEPTH bundles of `RENAME_WIDTH

---
 rtl/rename_queue_pkg.sv | 34 +++
 rtl/rename_queue_ctrl.sv | 94 +++++++++
 rtl/rename_queue.sv | 66 ++++++
 tb/tb_rename_queue.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/rename_queue_pkg.sv
// Shared types for the decode -> rename queue: micro-op layout, bundle
// width and default queue depth. RENAME_QUEUE_BYPASS_EN, consumed by the
// queue files, enables the zero-latency empty-queue bypass.
`ifndef RENAME_WIDTH
`define RENAME_WIDTH 2
`endif
`ifndef RENAME_QUEUE_DEPTH
`define RENAME_QUEUE_DEPTH 4
`endif

package rename_queue_pkg;

  localparam int RENAME_WIDTH       = `RENAME_WIDTH;
  localparam int RENAME_QUEUE_DEPTH = `RENAME_QUEUE_DEPTH;

  typedef struct packed {
    logic       valid;
    logic [6:0] opcode;
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [4:0] rs2;
  } micro_op_t;

  typedef micro_op_t [RENAME_WIDTH-1:0] bundle_t;

  // A bundle whose slots are all invalid is a decode bubble and is never stored.
  function automatic logic bundle_nonempty(input bundle_t b);
    logic any;
    any = 1'b0;
    for (int i = 0; i < RENAME_WIDTH; i++) any |= b[i].valid;
    return any;
  endfunction

endpackage

// File: rtl/rename_queue_ctrl.sv
// Pointer, occupancy and handshake control for rename_queue.
// Optional feature macro: RENAME_QUEUE_BYPASS_EN (empty-queue bypass).
module rename_queue_ctrl
  import rename_queue_pkg::*;
#(
  parameter  int DEPTH = RENAME_QUEUE_DEPTH,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             flush,
  input  logic             in_valid,
  input  logic             in_nonempty,
  output logic             in_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             wr_en,
  output logic [PTR_W-1:0] head,
  output logic [PTR_W-1:0] tail,
`ifdef RENAME_QUEUE_BYPASS_EN
  output logic             bypass,
`endif
  output logic [PTR_W:0]   count
);

  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

  logic [PTR_W-1:0] head_q, tail_q;
  logic [PTR_W:0]   count_q, count_d;
  logic             empty, full, enq_hs, deq_hs, rd_en, byp_take;

  assign empty = (count_q == '0);
  assign full  = (count_q == FULL_CNT);

  // Input/output handshakes; flush blocks both sides for the cycle.
  always_comb begin
    in_ready  = reset_n & ~full & ~flush;
    out_valid = ~empty & ~flush;
    byp_take  = 1'b0;
`ifdef RENAME_QUEUE_BYPASS_EN
    bypass    = empty & ~flush & reset_n & in_valid & in_nonempty;
    out_valid = out_valid | bypass;
    byp_take  = bypass & out_ready;
`endif
    enq_hs = in_valid & in_ready;
    deq_hs = out_valid & out_ready;
    // A bypassed bundle consumed this cycle never touches storage.
    wr_en  = enq_hs & in_nonempty & ~byp_take;
    rd_en  = deq_hs & ~byp_take;
  end

  // Occupancy update from the write/read pair.
  always_comb begin
    count_d = count_q;
    case ({wr_en, rd_en})
      2'b10:   count_d = count_q + (PTR_W+1)'(1);
      2'b01:   count_d = count_q - (PTR_W+1)'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointer and count registers; flush returns the queue to its reset shape.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else if (flush) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      if (wr_en) tail_q <= tail_q + PTR_W'(1);
      if (rd_en) head_q <= head_q + PTR_W'(1);
      count_q <= count_d;
    end
  end

`ifndef SYNTHESIS
  // Occupancy must stay within 0..DEPTH.
  always_ff @(posedge clock) begin
    if (reset_n && !flush) begin
      assert (!(rd_en && empty)) else $error("rename_queue underflow");
      assert (!(wr_en && !rd_en && full)) else $error("rename_queue overflow");
      assert (count_q <= FULL_CNT) else $error("rename_queue count out of range");
    end
  end
`endif

  assign head  = head_q;
  assign tail  = tail_q;
  assign count = count_q;

endmodule

// File: rtl/rename_queue.sv
// Decoupling FIFO between decode and rename: circular bundle storage plus
// output mux; pointer/handshake control lives in rename_queue_ctrl.
// Optional feature macro: RENAME_QUEUE_BYPASS_EN (empty-queue bypass).
module rename_queue
  import rename_queue_pkg::*;
#(
  parameter  int DEPTH = RENAME_QUEUE_DEPTH,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic           clock,
  input  logic           reset_n,
  input  logic           flush,
  input  logic           in_valid,
  output logic           in_ready,
  input  bundle_t        uop_in,
  output logic           out_valid,
  input  logic           out_ready,
  output bundle_t        uop_out,
  output logic [PTR_W:0] count
);

  bundle_t          mem [DEPTH];
  logic [PTR_W-1:0] head, tail;
  logic             wr_en, in_nonempty;
`ifdef RENAME_QUEUE_BYPASS_EN
  logic             bypass;
`endif

  assign in_nonempty = bundle_nonempty(uop_in);

  rename_queue_ctrl #(.DEPTH(DEPTH)) u_ctrl (
    .clock       (clock),
    .reset_n     (reset_n),
    .flush       (flush),
    .in_valid    (in_valid),
    .in_nonempty (in_nonempty),
    .in_ready    (in_ready),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .wr_en       (wr_en),
    .head        (head),
    .tail        (tail),
`ifdef RENAME_QUEUE_BYPASS_EN
    .bypass      (bypass),
`endif
    .count       (count)
  );

  // Bundle storage; cleared on reset so the idle output reads as all-zero.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (wr_en) begin
      mem[tail] <= uop_in;
    end
  end

  // Oldest bundle to rename, or the incoming bundle when bypassing an empty queue.
  always_comb begin
    uop_out = mem[head];
`ifdef RENAME_QUEUE_BYPASS_EN
    if (bypass) uop_out = uop_in;
`endif
  end

endmodule

// File: tb/tb_rename_queue.sv
module tb_rename_queue;
  import rename_queue_pkg::*;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       flush = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  bundle_t    uop_in = '0;
  logic       out_valid;
  logic       out_ready = 1'b0;
  bundle_t    uop_out;
  logic [2:0] count;

  int passed = 0;
  int total  = 0;

  rename_queue dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .uop_in    (uop_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .uop_out   (uop_out),
    .count     (count)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic       fl, iv, bub;
    logic [7:0] tag;
    logic       ordy;
    logic       ir, ov;
    logic [2:0] cnt;
    logic [7:0] otag;
  } vec_t;

  vec_t vecs [30];

  function automatic bundle_t mk(input logic [7:0] tag, input logic bub);
    bundle_t b;
    for (int i = 0; i < RENAME_WIDTH; i++) begin
      b[i].valid  = ~bub;
      b[i].opcode = tag[6:0] + 7'(i);
      b[i].rd     = tag[4:0] ^ 5'(i + 1);
      b[i].rs1    = tag[7:3];
      b[i].rs2    = 5'(i + 3);
    end
    return b;
  endfunction

  function automatic vec_t v(input logic fl, iv, bub, input logic [7:0] tag,
                             input logic ordy, ir, ov, input logic [2:0] cnt,
                             input logic [7:0] otag);
    vec_t r;
    r.fl = fl; r.iv = iv; r.bub = bub; r.tag = tag; r.ordy = ordy;
    r.ir = ir; r.ov = ov; r.cnt = cnt; r.otag = otag;
    return r;
  endfunction

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask

  task automatic drive(input logic fl, iv, bub, input logic [7:0] tag, input logic ordy);
    flush = fl; in_valid = iv; out_ready = ordy; uop_in = mk(tag, bub);
  endtask

  initial begin
    //               fl iv bb tag    or ir ov cnt otag
    vecs[0]  = v(0, 0, 0, 8'h00, 0, 1, 0, 0, 8'h00);  // first cycle out of reset
    vecs[1]  = v(0, 1, 0, 8'h11, 0, 1, 0, 0, 8'h00);  // A
    vecs[2]  = v(0, 1, 0, 8'h22, 0, 1, 1, 1, 8'h11);  // B
    vecs[3]  = v(0, 1, 0, 8'h33, 0, 1, 1, 2, 8'h11);  // C
    vecs[4]  = v(0, 1, 0, 8'h44, 0, 1, 1, 3, 8'h11);  // D
    vecs[5]  = v(0, 1, 0, 8'h55, 0, 0, 1, 4, 8'h11);  // E held, full
    vecs[6]  = v(0, 1, 0, 8'h55, 0, 0, 1, 4, 8'h11);
    vecs[7]  = v(0, 0, 0, 8'h00, 1, 0, 1, 4, 8'h11);  // full refuses despite out_ready
    vecs[8]  = v(0, 0, 0, 8'h00, 1, 1, 1, 3, 8'h22);
    vecs[9]  = v(0, 0, 0, 8'h00, 1, 1, 1, 2, 8'h33);
    vecs[10] = v(0, 0, 0, 8'h00, 1, 1, 1, 1, 8'h44);
    vecs[11] = v(0, 0, 0, 8'h00, 0, 1, 0, 0, 8'h00);
    vecs[12] = v(0, 1, 0, 8'h61, 1, 1, 0, 0, 8'h00);  // streaming
    vecs[13] = v(0, 1, 0, 8'h62, 1, 1, 1, 1, 8'h61);
    vecs[14] = v(0, 1, 0, 8'h63, 1, 1, 1, 1, 8'h62);
    vecs[15] = v(0, 0, 0, 8'h00, 1, 1, 1, 1, 8'h63);
    vecs[16] = v(0, 0, 0, 8'h00, 0, 1, 0, 0, 8'h00);
    vecs[17] = v(0, 1, 1, 8'h6a, 0, 1, 0, 0, 8'h00);  // bubble
    vecs[18] = v(0, 0, 0, 8'h00, 0, 1, 0, 0, 8'h00);
    vecs[19] = v(0, 1, 0, 8'h71, 0, 1, 0, 0, 8'h00);
    vecs[20] = v(0, 1, 0, 8'h72, 0, 1, 1, 1, 8'h71);
    vecs[21] = v(0, 1, 0, 8'h73, 0, 1, 1, 2, 8'h71);
    vecs[22] = v(1, 1, 0, 8'h74, 1, 0, 0, 3, 8'h00);  // flush beats both handshakes
    vecs[23] = v(0, 0, 0, 8'h00, 0, 1, 0, 0, 8'h00);
    vecs[24] = v(0, 1, 0, 8'h81, 0, 1, 0, 0, 8'h00);
    vecs[25] = v(0, 0, 0, 8'h00, 0, 1, 1, 1, 8'h81);  // pointers restarted at slot 0
    vecs[26] = v(0, 0, 0, 8'h00, 1, 1, 1, 1, 8'h81);
    vecs[27] = v(0, 0, 0, 8'h00, 0, 1, 0, 0, 8'h00);
    vecs[28] = v(1, 0, 0, 8'h00, 0, 0, 0, 0, 8'h00);  // flush on empty
    vecs[29] = v(0, 0, 0, 8'h00, 0, 1, 0, 0, 8'h00);

    // Reset held: outputs quiet
    repeat (2) @(negedge clock);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_in_ready",  64'(in_ready),  64'd0);
    chk("rst_count",     64'(count),     64'd0);
    chk("rst_uop_out",   64'(uop_out),   64'd0);
    reset_n = 1'b1;

`ifndef RENAME_QUEUE_BYPASS_EN
    for (int i = 0; i < 30; i++) begin
      @(posedge clock); #1;
      drive(vecs[i].fl, vecs[i].iv, vecs[i].bub, vecs[i].tag, vecs[i].ordy);
      @(negedge clock);
      chk($sformatf("v%0d_in_ready", i),  64'(in_ready),  64'(vecs[i].ir));
      chk($sformatf("v%0d_out_valid", i), 64'(out_valid), 64'(vecs[i].ov));
      chk($sformatf("v%0d_count", i),     64'(count),     64'(vecs[i].cnt));
      if (vecs[i].ov)
        chk($sformatf("v%0d_uop_out", i), 64'(uop_out), 64'(mk(vecs[i].otag, 1'b0)));
    end
`endif

    // Empty queue offered a bundle with out_ready=1
    @(posedge clock); #1;
    drive(0, 1, 0, 8'h91, 1);
    @(negedge clock);
`ifdef RENAME_QUEUE_BYPASS_EN
    chk("byp_out_valid", 64'(out_valid), 64'd1);
    chk("byp_uop_out",   64'(uop_out),   64'(mk(8'h91, 1'b0)));
`else
    chk("nobyp_out_valid", 64'(out_valid), 64'd0);
`endif
    chk("byp_in_ready", 64'(in_ready), 64'd1);
    @(posedge clock); #1;
    drive(0, 0, 0, 8'h00, 0);
    @(negedge clock);
`ifdef RENAME_QUEUE_BYPASS_EN
    chk("byp_count_after", 64'(count), 64'd0);
`else
    chk("nobyp_count_after", 64'(count), 64'd1);
    chk("nobyp_uop_after",   64'(uop_out), 64'(mk(8'h91, 1'b0)));
    @(posedge clock); #1;
    drive(0, 0, 0, 8'h00, 1);
    @(posedge clock); #1;
    drive(0, 0, 0, 8'h00, 0);
    @(negedge clock);
    chk("nobyp_drained", 64'(count), 64'd0);
`endif

    // Async reset mid-cycle with a stored bundle
    @(posedge clock); #1;
    drive(0, 1, 0, 8'ha5, 0);
    @(posedge clock); #1;
    drive(0, 0, 0, 8'h00, 0);
    #2;
    chk("pre_areset_count", 64'(count), 64'd1);
    reset_n = 1'b0;
    #1;
    chk("areset_count",     64'(count),     64'd0);
    chk("areset_out_valid", 64'(out_valid), 64'd0);
    chk("areset_in_ready",  64'(in_ready),  64'd0);
    chk("areset_uop_out",   64'(uop_out),   64'd0);
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    chk("post_areset_in_ready", 64'(in_ready), 64'd1);
    chk("post_areset_count",    64'(count),    64'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
